// File: rtl/atm_session_ctrl.sv
// ATM session front end: card/PIN login, command handshake, timed core
// request issue with sampled result, idle timeout and per-account lockout.
module atm_session_ctrl #(
    parameter int MAX_TRIES    = 3,
    parameter int RESP_WAIT    = 2,
    parameter int IDLE_TIMEOUT = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        card_valid,
    input  logic [3:0]  card_acct,
    input  logic [3:0]  card_pin,
    input  logic        pin_valid,
    input  logic [3:0]  pin_entry,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [9:0]  cmd_amount,
    input  logic [3:0]  cmd_acct_d,
    output logic [1:0]  atm_select,
    output logic [9:0]  atm_amount,
    output logic [3:0]  atm_acct_s,
    output logic [3:0]  atm_acct_d,
    input  logic [1:0]  atm_result,
    input  logic [9:0]  atm_balance,
    output logic        rsp_valid,
    output logic [2:0]  rsp_code,
    output logic [9:0]  rsp_balance,
    output logic        session_active
);

    localparam int TRY_W  = $clog2(MAX_TRIES + 1);
    localparam int TO_W   = $clog2(IDLE_TIMEOUT + 1);
    localparam int WAIT_W = $clog2(RESP_WAIT + 1);

    localparam logic [2:0] RSP_OK      = 3'd0;
    localparam logic [2:0] RSP_CLOSED  = 3'd1;
    localparam logic [2:0] RSP_BADPIN  = 3'd2;
    localparam logic [2:0] RSP_LOCKED  = 3'd3;
    localparam logic [2:0] RSP_NOFUNDS = 3'd4;
    localparam logic [2:0] RSP_TIMEOUT = 3'd5;
    localparam logic [2:0] RSP_BADDEST = 3'd6;

    typedef enum logic [1:0] {S_IDLE, S_PIN, S_MENU, S_ISSUE} state_t;

    state_t              state_r, state_s;
    logic [3:0]          acct_r, acct_s;
    logic [3:0]          pin_r, pin_s;
    logic [TRY_W-1:0]    tries_r, tries_s, tries_inc_s;
    logic [TO_W-1:0]     to_r, to_s;
    logic [WAIT_W-1:0]   wait_r, wait_s;
    logic [15:0]         lock_r, lock_s;
    logic [1:0]          op_r, op_s;
    logic [9:0]          amount_r, amount_s;
    logic [3:0]          dest_r, dest_s;
    logic                rsp_valid_s;
    logic [2:0]          rsp_code_s;
    logic [9:0]          rsp_balance_s;
    logic                cmd_ready_s;
    logic                active_s;
    logic [1:0]          sel_s;
    logic [9:0]          amt_s;
    logic [3:0]          src_s;
    logic [3:0]          dst_s;
    logic                hs_s;

    // Next-state, bookkeeping and registered-output values for the session FSM
    always_comb begin
        state_s       = state_r;
        acct_s        = acct_r;
        pin_s         = pin_r;
        tries_s       = tries_r;
        to_s          = to_r;
        wait_s        = wait_r;
        lock_s        = lock_r;
        op_s          = op_r;
        amount_s      = amount_r;
        dest_s        = dest_r;
        rsp_valid_s   = 1'b0;
        rsp_code_s    = rsp_code;
        rsp_balance_s = rsp_balance;
        tries_inc_s   = tries_r + TRY_W'(1);
        hs_s          = (state_r == S_MENU) && cmd_valid && cmd_ready;

        case (state_r)
            S_IDLE: begin
                if (card_valid) begin
                    if (lock_r[card_acct]) begin
                        rsp_valid_s = 1'b1;
                        rsp_code_s  = RSP_LOCKED;
                    end else begin
                        acct_s  = card_acct;
                        pin_s   = card_pin;
                        tries_s = '0;
                        to_s    = '0;
                        state_s = S_PIN;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_PIN: begin
                if (pin_valid) begin
                    to_s        = '0;
                    rsp_valid_s = 1'b1;
                    if (pin_entry == pin_r) begin
                        rsp_code_s = RSP_OK;
                        state_s    = S_MENU;
                    end else if (tries_inc_s == TRY_W'(MAX_TRIES)) begin
                        lock_s[acct_r] = 1'b1;
                        tries_s        = '0;
                        rsp_code_s     = RSP_LOCKED;
                        state_s        = S_IDLE;
                    end else begin
                        tries_s    = tries_inc_s;
                        rsp_code_s = RSP_BADPIN;
                    end
                end else if (to_r == TO_W'(IDLE_TIMEOUT - 1)) begin
                    to_s        = '0;
                    rsp_valid_s = 1'b1;
                    rsp_code_s  = RSP_TIMEOUT;
                    state_s     = S_IDLE;
                end else begin
                    to_s = to_r + TO_W'(1);
                end
            end
            S_MENU: begin
                if (hs_s) begin
                    to_s = '0;
                    if (cmd_op == 2'd0) begin
                        rsp_valid_s = 1'b1;
                        rsp_code_s  = RSP_CLOSED;
                        state_s     = S_IDLE;
                    end else if ((cmd_op == 2'd3) && (cmd_acct_d == acct_r)) begin
                        rsp_valid_s = 1'b1;
                        rsp_code_s  = RSP_BADDEST;
                    end else if ((cmd_op != 2'd1) && (cmd_amount == 10'd0)) begin
                        // zero-value move: acknowledge without touching the core
                        rsp_valid_s = 1'b1;
                        rsp_code_s  = RSP_OK;
                    end else begin
                        op_s     = cmd_op;
                        amount_s = cmd_amount;
                        dest_s   = (cmd_op == 2'd3) ? cmd_acct_d : 4'd0;
                        wait_s   = '0;
                        state_s  = S_ISSUE;
                    end
                end else if (to_r == TO_W'(IDLE_TIMEOUT - 1)) begin
                    to_s        = '0;
                    rsp_valid_s = 1'b1;
                    rsp_code_s  = RSP_TIMEOUT;
                    state_s     = S_IDLE;
                end else begin
                    to_s = to_r + TO_W'(1);
                end
            end
            S_ISSUE: begin
                if (wait_r == WAIT_W'(RESP_WAIT - 1)) begin
                    // last held cycle: the core has settled, take its answer
                    rsp_valid_s   = 1'b1;
                    rsp_balance_s = atm_balance;
                    if ((op_r == 2'd1) || (atm_result == 2'd3)) begin
                        rsp_code_s = RSP_OK;
                    end else begin
                        rsp_code_s = RSP_NOFUNDS;
                    end
                    wait_s  = '0;
                    to_s    = '0;
                    state_s = S_MENU;
                end else begin
                    wait_s = wait_r + WAIT_W'(1);
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase

        // ready only in MENU, and withheld on the first MENU cycle after ISSUE
        cmd_ready_s = (state_s == S_MENU) && (state_r != S_ISSUE);
        active_s    = (state_s != S_IDLE);

        if (state_s == S_ISSUE) begin
            sel_s = op_s;
            amt_s = amount_s;
            src_s = acct_s;
            dst_s = dest_s;
        end else begin
            sel_s = 2'd1;
            amt_s = 10'd0;
            src_s = 4'd0;
            dst_s = 4'd0;
        end
    end

    // State, bookkeeping and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= S_IDLE;
            acct_r         <= 4'd0;
            pin_r          <= 4'd0;
            tries_r        <= '0;
            to_r           <= '0;
            wait_r         <= '0;
            lock_r         <= 16'd0;
            op_r           <= 2'd0;
            amount_r       <= 10'd0;
            dest_r         <= 4'd0;
            cmd_ready      <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_code       <= 3'd0;
            rsp_balance    <= 10'd0;
            session_active <= 1'b0;
            atm_select     <= 2'd1;
            atm_amount     <= 10'd0;
            atm_acct_s     <= 4'd0;
            atm_acct_d     <= 4'd0;
        end else begin
            state_r        <= state_s;
            acct_r         <= acct_s;
            pin_r          <= pin_s;
            tries_r        <= tries_s;
            to_r           <= to_s;
            wait_r         <= wait_s;
            lock_r         <= lock_s;
            op_r           <= op_s;
            amount_r       <= amount_s;
            dest_r         <= dest_s;
            cmd_ready      <= cmd_ready_s;
            rsp_valid      <= rsp_valid_s;
            rsp_code       <= rsp_code_s;
            rsp_balance    <= rsp_balance_s;
            session_active <= active_s;
            atm_select     <= sel_s;
            atm_amount     <= amt_s;
            atm_acct_s     <= src_s;
            atm_acct_d     <= dst_s;
        end
    end

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Directed self-checking bench for atm_session_ctrl (default parameters).
module tb_atm_session_ctrl;

    logic        clk;
    logic        rst;
    logic        card_valid;
    logic [3:0]  card_acct;
    logic [3:0]  card_pin;
    logic        pin_valid;
    logic [3:0]  pin_entry;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [9:0]  cmd_amount;
    logic [3:0]  cmd_acct_d;
    logic [1:0]  atm_select;
    logic [9:0]  atm_amount;
    logic [3:0]  atm_acct_s;
    logic [3:0]  atm_acct_d;
    logic [1:0]  atm_result;
    logic [9:0]  atm_balance;
    logic        rsp_valid;
    logic [2:0]  rsp_code;
    logic [9:0]  rsp_balance;
    logic        session_active;

    int checks = 0;
    int errors = 0;

    atm_session_ctrl dut (
        .clk(clk), .rst(rst),
        .card_valid(card_valid), .card_acct(card_acct), .card_pin(card_pin),
        .pin_valid(pin_valid), .pin_entry(pin_entry),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_amount(cmd_amount), .cmd_acct_d(cmd_acct_d),
        .atm_select(atm_select), .atm_amount(atm_amount),
        .atm_acct_s(atm_acct_s), .atm_acct_d(atm_acct_d),
        .atm_result(atm_result), .atm_balance(atm_balance),
        .rsp_valid(rsp_valid), .rsp_code(rsp_code), .rsp_balance(rsp_balance),
        .session_active(session_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic insert_card(input logic [3:0] a, input logic [3:0] p);
        card_valid = 1'b1; card_acct = a; card_pin = p;
        tick();
        card_valid = 1'b0;
    endtask

    task automatic enter_pin(input logic [3:0] p);
        pin_valid = 1'b1; pin_entry = p;
        tick();
        pin_valid = 1'b0;
    endtask

    // returns right after the accepting edge
    task automatic send_cmd(input logic [1:0] op, input logic [9:0] amt, input logic [3:0] dst);
        int n;
        cmd_valid = 1'b1; cmd_op = op; cmd_amount = amt; cmd_acct_d = dst;
        n = 0;
        while (!cmd_ready && n < 20) begin
            tick();
            n++;
        end
        check("cmd_ready_seen", cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic expect_rsp(input string tag, input logic [2:0] code);
        check({tag, "_valid"}, rsp_valid, 1'b1);
        check({tag, "_code"}, rsp_code, code);
    endtask

    initial begin
        rst = 1'b1;
        card_valid = 1'b0; card_acct = 4'd0; card_pin = 4'd0;
        pin_valid = 1'b0; pin_entry = 4'd0;
        cmd_valid = 1'b0; cmd_op = 2'd0; cmd_amount = 10'd0; cmd_acct_d = 4'd0;
        atm_result = 2'd0; atm_balance = 10'd0;
        tick(); tick();
        check("rst_cmd_ready", cmd_ready, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_active", session_active, 1'b0);
        check("rst_select", atm_select, 2'd1);
        check("rst_amount", atm_amount, 10'd0);
        rst = 1'b0;
        tick();

        // login acct 4, balance query
        insert_card(4'd4, 4'd5);
        check("card4_norsp", rsp_valid, 1'b0);
        check("card4_active", session_active, 1'b1);
        enter_pin(4'd5);
        expect_rsp("login4", 3'd0);
        tick();
        check("login4_pulse", rsp_valid, 1'b0);
        atm_result = 2'd3; atm_balance = 10'd200;
        send_cmd(2'd1, 10'd0, 4'd0);
        check("bal_sel1", atm_select, 2'd1);
        check("bal_src1", atm_acct_s, 4'd4);
        check("bal_rv1", rsp_valid, 1'b0);
        tick();
        check("bal_src2", atm_acct_s, 4'd4);
        check("bal_rv2", rsp_valid, 1'b0);
        tick();
        expect_rsp("bal", 3'd0);
        check("bal_balance", rsp_balance, 10'd200);
        check("bal_src_idle", atm_acct_s, 4'd0);
        check("bal_ready_gap", cmd_ready, 1'b0);
        send_cmd(2'd0, 10'd0, 4'd0);
        expect_rsp("exit4", 3'd1);
        check("exit4_active", session_active, 1'b0);

        // acct 3 withdrawals
        insert_card(4'd3, 4'd7);
        enter_pin(4'd7);
        expect_rsp("login3", 3'd0);
        atm_result = 2'd3; atm_balance = 10'd130;
        send_cmd(2'd2, 10'd70, 4'd9);
        check("wd_sel", atm_select, 2'd2);
        check("wd_amt", atm_amount, 10'd70);
        check("wd_src", atm_acct_s, 4'd3);
        check("wd_dst", atm_acct_d, 4'd0);
        tick(); tick();
        expect_rsp("wd_ok", 3'd0);
        check("wd_bal", rsp_balance, 10'd130);
        check("wd_amt_idle", atm_amount, 10'd0);
        atm_result = 2'd0; atm_balance = 10'd130;
        send_cmd(2'd2, 10'd900, 4'd0);
        check("wd2_amt", atm_amount, 10'd900);
        tick(); tick();
        expect_rsp("wd_nofunds", 3'd4);
        check("wd2_amt_idle", atm_amount, 10'd0);
        atm_balance = 10'd777;
        send_cmd(2'd2, 10'd0, 4'd0);
        expect_rsp("wd_zero", 3'd0);
        check("wd_zero_bal", rsp_balance, 10'd130);
        check("wd_zero_noissue", atm_select, 2'd1);
        send_cmd(2'd0, 10'd0, 4'd0);
        expect_rsp("exit3", 3'd1);

        // acct 6 transfers
        insert_card(4'd6, 4'd1);
        enter_pin(4'd1);
        expect_rsp("login6", 3'd0);
        atm_result = 2'd3; atm_balance = 10'd55;
        send_cmd(2'd3, 10'd40, 4'd10);
        check("xf_sel", atm_select, 2'd3);
        check("xf_src", atm_acct_s, 4'd6);
        check("xf_dst", atm_acct_d, 4'd10);
        check("xf_amt", atm_amount, 10'd40);
        tick(); tick();
        expect_rsp("xf_ok", 3'd0);
        check("xf_bal", rsp_balance, 10'd55);
        send_cmd(2'd3, 10'd5, 4'd6);
        expect_rsp("xf_baddest", 3'd6);
        check("xf_bd_noissue", atm_select, 2'd1);
        check("xf_bd_active", session_active, 1'b1);
        send_cmd(2'd0, 10'd0, 4'd0);
        expect_rsp("exit6", 3'd1);

        // lockout acct 8
        insert_card(4'd8, 4'd2);
        enter_pin(4'd0);
        expect_rsp("pin_bad1", 3'd2);
        enter_pin(4'd1);
        expect_rsp("pin_bad2", 3'd2);
        enter_pin(4'd3);
        expect_rsp("pin_lock", 3'd3);
        check("lock_active", session_active, 1'b0);
        insert_card(4'd8, 4'd2);
        expect_rsp("relock", 3'd3);
        check("relock_active", session_active, 1'b0);
        insert_card(4'd4, 4'd5);
        enter_pin(4'd5);
        expect_rsp("login4b", 3'd0);

        // idle timeout in MENU: fires on the 1000th idle cycle
        for (int i = 0; i < 999; i++) tick();
        check("to_not_yet", rsp_valid, 1'b0);
        check("to_still_active", session_active, 1'b1);
        tick();
        expect_rsp("timeout", 3'd5);
        check("to_active", session_active, 1'b0);

        // reset in the middle of ISSUE
        insert_card(4'd4, 4'd5);
        enter_pin(4'd5);
        expect_rsp("login4c", 3'd0);
        send_cmd(2'd2, 10'd50, 4'd0);
        check("mid_sel", atm_select, 2'd2);
        #2 rst = 1'b1;
        #1;
        check("mrst_sel", atm_select, 2'd1);
        check("mrst_amt", atm_amount, 10'd0);
        check("mrst_src", atm_acct_s, 4'd0);
        check("mrst_active", session_active, 1'b0);
        check("mrst_ready", cmd_ready, 1'b0);
        check("mrst_code", rsp_code, 3'd0);
        tick();
        rst = 1'b0;
        tick();
        insert_card(4'd8, 4'd2);
        check("unlock_norsp", rsp_valid, 1'b0);
        check("unlock_active", session_active, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
